decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage for the TRSQ8 core. Accepts one instruction word per cycle over a valid/ready handshake and registers the decoded control word into a single output slot. Resolves SKZ/SKC skips, NOP and HALT locally; only executable instructions reach the execute stage. Sits between the instruction fetch and the ALU/file-register execute stage.

---
 rtl/trsq8_pkg.sv | 51 +++++
 rtl/decode_stage_if.sv | 41 ++++
 rtl/decode_stage_op_lut.sv | 44 ++++
 rtl/decode_stage.sv | 86 ++++++++
 tb/tb_decode_stage.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trsq8_pkg.sv
// trsq8_pkg: shared opcodes, ALU select codes, control word and FSM state for the TRSQ8 decode stage
package trsq8_pkg;

    localparam int ADDR_W_DEF = 8;

    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_HALT = 7'b0000001;
    localparam logic [6:0] OP_RET  = 7'b0000010;
    localparam logic [6:0] OP_SKZ  = 7'b0000101;
    localparam logic [6:0] OP_SKC  = 7'b0000110;
    localparam logic [6:0] OP_ADD  = 7'b0100000;
    localparam logic [6:0] OP_SUB  = 7'b0100001;
    localparam logic [6:0] OP_AND  = 7'b0100111;
    localparam logic [6:0] OP_OR   = 7'b0101000;
    localparam logic [6:0] OP_NOT  = 7'b0101001;
    localparam logic [6:0] OP_XOR  = 7'b0101011;
    localparam logic [6:0] OP_ST   = 7'b0101100;
    localparam logic [6:0] OP_LD   = 7'b0101101;
    localparam logic [6:0] OP_LDL  = 7'b0101110;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_NOT  = 5'b00100;
    localparam logic [4:0] ALU_XOR  = 5'b00101;
    localparam logic [4:0] ALU_LD   = 5'b01000;
    localparam logic [4:0] ALU_ST   = 5'b01001;
    localparam logic [4:0] ALU_NONE = 5'b11111;

    typedef struct packed {
        logic [4:0] alu_sel;
        logic       muxa;
        logic       muxb;
        logic       ld;
        logic       st;
        logic       ret;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{ALU_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    typedef enum logic {RUN, HALTED} state_t;

    // Opcodes handled entirely inside the decode stage and never emitted.
    function automatic logic is_local(input logic [6:0] op);
        return op == OP_NOP || op == OP_HALT || op == OP_SKZ || op == OP_SKC;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side handshake, ALU flags, control inputs and decoded-slot outputs of decode_stage
//   slave  : decode stage side (takes instr/flags/flush/wake/out_ready, drives ready and slot outputs)
//   master : fetch/execute side (the mirror image)
interface decode_stage_if #(
    parameter int ADDR_W = trsq8_pkg::ADDR_W_DEF
);
    localparam int INSTR_W = ADDR_W + 7;

    logic [INSTR_W-1:0] instr_ip;
    logic               instr_valid_ip;
    logic               instr_ready_op;
    logic               zero_ip;
    logic               carry_ip;
    logic               flush_ip;
    logic               wake_ip;
    logic               out_valid_op;
    logic               out_ready_ip;
    logic [4:0]         alu_sel_op;
    logic               muxa_sel_op;
    logic               muxb_sel_op;
    logic [ADDR_W-1:0]  sram_addr_op;
    logic               sram_ld_op;
    logic               sram_st_op;
    logic               return_op;
    logic               jump_op;
    logic               illegal_op;
    logic               halted_op;

    modport slave (
        input  instr_ip, instr_valid_ip, zero_ip, carry_ip, flush_ip, wake_ip, out_ready_ip,
        output instr_ready_op, out_valid_op, alu_sel_op, muxa_sel_op, muxb_sel_op, sram_addr_op,
               sram_ld_op, sram_st_op, return_op, jump_op, illegal_op, halted_op
    );

    modport master (
        output instr_ip, instr_valid_ip, zero_ip, carry_ip, flush_ip, wake_ip, out_ready_ip,
        input  instr_ready_op, out_valid_op, alu_sel_op, muxa_sel_op, muxb_sel_op, sram_addr_op,
               sram_ld_op, sram_st_op, return_op, jump_op, illegal_op, halted_op
    );

endinterface

// File: rtl/decode_stage_op_lut.sv
// op_lut: combinational opcode + operand -> control word and file-register address
//   opcode_i  : 7-bit opcode
//   operand_i : ADDR_W-bit operand
//   ctrl_o    : decoded control word
//   addr_o    : file-register address (operand for register/bit classes, else 0)
module op_lut
    import trsq8_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [6:0]        opcode_i,
    input  logic [ADDR_W-1:0] operand_i,
    output ctrl_t             ctrl_o,
    output logic [ADDR_W-1:0] addr_o
);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        addr_o = (opcode_i[6:5] == 2'b01 || opcode_i[6:5] == 2'b10) ? operand_i : '0;
        case (opcode_i[6:5])
            2'b00: begin
                if (opcode_i == OP_RET) ctrl_o.ret = 1'b1;
                else if (!is_local(opcode_i)) ctrl_o.illegal = 1'b1;
            end
            2'b01: begin
                case (opcode_i)
                    OP_ADD: begin ctrl_o.alu_sel = ALU_ADD; ctrl_o.ld = 1'b1; end
                    OP_SUB: begin ctrl_o.alu_sel = ALU_SUB; ctrl_o.ld = 1'b1; end
                    OP_AND: begin ctrl_o.alu_sel = ALU_AND; ctrl_o.ld = 1'b1; end
                    OP_OR:  begin ctrl_o.alu_sel = ALU_OR;  ctrl_o.ld = 1'b1; end
                    OP_NOT: begin ctrl_o.alu_sel = ALU_NOT; ctrl_o.ld = 1'b1; end
                    OP_XOR: begin ctrl_o.alu_sel = ALU_XOR; ctrl_o.ld = 1'b1; end
                    OP_ST:  begin ctrl_o.alu_sel = ALU_ST;  ctrl_o.st = 1'b1; end
                    OP_LD:  begin ctrl_o.alu_sel = ALU_LD;  ctrl_o.ld = 1'b1; end
                    OP_LDL: begin ctrl_o.alu_sel = ALU_LD;  ctrl_o.muxa = 1'b1; end
                    default: ctrl_o.illegal = 1'b1;
                endcase
            end
            2'b10:   ctrl_o.muxb = 1'b1;
            default: ctrl_o.jump = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered TRSQ8 instruction decode with skip resolution, HALT/wake FSM and one output slot
//   clk_ip : clock, all state on rising edge
//   rst_ip : synchronous active-high reset
//   bus    : decode_stage_if.slave (instr handshake, flags, flush/wake, decoded slot outputs)
module decode_stage
    import trsq8_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic           clk_ip,
    input logic           rst_ip,
    decode_stage_if.slave bus
);

    localparam int INSTR_W = ADDR_W + 7;

    logic [6:0]        opcode;
    logic [ADDR_W-1:0] operand;
    ctrl_t             lut_ctrl;
    logic [ADDR_W-1:0] lut_addr;

    state_t            state_q, state_d;
    logic              skip_q, skip_d;
    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic ready, accept, live, emit, skip_hit;

    assign opcode  = bus.instr_ip[INSTR_W-1 -: 7];
    assign operand = bus.instr_ip[ADDR_W-1:0];

    op_lut #(.ADDR_W(ADDR_W)) u_lut (
        .opcode_i  (opcode),
        .operand_i (operand),
        .ctrl_o    (lut_ctrl),
        .addr_o    (lut_addr)
    );

    always_comb begin
        ready    = (state_q == RUN) & ~bus.flush_ip & (~valid_q | bus.out_ready_ip);
        accept   = bus.instr_valid_ip & ready;
        // A pending skip consumes the next accepted word, whatever it is.
        live     = accept & ~skip_q;
        emit     = live & ~is_local(opcode);
        skip_hit = ((opcode == OP_SKZ) & bus.zero_ip) | ((opcode == OP_SKC) & bus.carry_ip);
        state_d  = state_q;
        if (state_q == RUN && live && opcode == OP_HALT) state_d = HALTED;
        else if (state_q == HALTED && bus.wake_ip) state_d = RUN;
        skip_d   = bus.flush_ip ? 1'b0 : accept ? (live & skip_hit) : skip_q;
        // flush never coincides with emit because it blocks acceptance.
        valid_d  = ~bus.flush_ip & (emit | (valid_q & ~bus.out_ready_ip));
        ctrl_d   = emit ? lut_ctrl : valid_d ? ctrl_q : CTRL_IDLE;
        addr_d   = emit ? lut_addr : valid_d ? addr_q : '0;
    end

    always_ff @(posedge clk_ip) begin
        if (rst_ip) begin
            state_q <= RUN;
            skip_q  <= 1'b0;
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.instr_ready_op = ready;
    assign bus.out_valid_op   = valid_q;
    assign bus.alu_sel_op     = ctrl_q.alu_sel;
    assign bus.muxa_sel_op    = ctrl_q.muxa;
    assign bus.muxb_sel_op    = ctrl_q.muxb;
    assign bus.sram_addr_op   = addr_q;
    assign bus.sram_ld_op     = ctrl_q.ld;
    assign bus.sram_st_op     = ctrl_q.st;
    assign bus.return_op      = ctrl_q.ret;
    assign bus.jump_op        = ctrl_q.jump;
    assign bus.illegal_op     = ctrl_q.illegal;
    assign bus.halted_op      = (state_q == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (ADDR_W=8 and ADDR_W=10 builds)
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vecs = 0;
    int errs = 0;

    localparam logic [6:0] NOP  = 7'b0000000;
    localparam logic [6:0] HALT = 7'b0000001;
    localparam logic [6:0] RET  = 7'b0000010;
    localparam logic [6:0] SKZ  = 7'b0000101;
    localparam logic [6:0] SKC  = 7'b0000110;
    localparam logic [6:0] ADD  = 7'b0100000;
    localparam logic [6:0] SUB  = 7'b0100001;
    localparam logic [6:0] AND_ = 7'b0100111;
    localparam logic [6:0] OR_  = 7'b0101000;
    localparam logic [6:0] NOT_ = 7'b0101001;
    localparam logic [6:0] XOR_ = 7'b0101011;
    localparam logic [6:0] ST   = 7'b0101100;
    localparam logic [6:0] LD   = 7'b0101101;
    localparam logic [6:0] LDL  = 7'b0101110;

    // Observed slot word: {valid, alu[4:0], muxa, muxb, ld, st, ret, jump, illegal, halted}
    localparam logic [13:0] RST_OBS = {1'b0, 5'b11111, 7'b0000000, 1'b0};

    decode_stage_if #(.ADDR_W(8))  b();
    decode_stage_if #(.ADDR_W(10)) b10();

    decode_stage #(.ADDR_W(8))  dut   (.clk_ip(clk), .rst_ip(rst), .bus(b));
    decode_stage #(.ADDR_W(10)) dut10 (.clk_ip(clk), .rst_ip(rst), .bus(b10));

    always #5 clk = ~clk;

    function automatic logic [13:0] obs8();
        return {b.out_valid_op, b.alu_sel_op, b.muxa_sel_op, b.muxb_sel_op, b.sram_ld_op,
                b.sram_st_op, b.return_op, b.jump_op, b.illegal_op, b.halted_op};
    endfunction

    function automatic logic [13:0] obs10();
        return {b10.out_valid_op, b10.alu_sel_op, b10.muxa_sel_op, b10.muxb_sel_op, b10.sram_ld_op,
                b10.sram_st_op, b10.return_op, b10.jump_op, b10.illegal_op, b10.halted_op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] op, input logic [7:0] opd);
        b.instr_ip = {op, opd};
        b.instr_valid_ip = 1'b1;
    endtask

    task automatic idle();
        b.instr_valid_ip = 1'b0;
        b.instr_ip = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vecs++;
        if (obs8() !== RST_OBS || b.sram_addr_op !== 8'h00) begin
            errs++;
            $display("FAIL reset_outputs: got %b/%h want %b/00", obs8(), b.sram_addr_op, RST_OBS);
        end
        vecs++;
        if (b.instr_ready_op !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: got %b want 1", b.instr_ready_op);
        end
        vecs++;
        if (obs10() !== RST_OBS || b10.sram_addr_op !== 10'h000) begin
            errs++;
            $display("FAIL reset_outputs_w10: got %b/%h want %b/000", obs10(), b10.sram_addr_op, RST_OBS);
        end
    endtask

    task automatic test_stream();
        logic [13:0] e;
        b.out_ready_ip = 1'b1;
        send(ADD, 8'h12);
        step();
        e = {1'b1, 5'b00000, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h12) begin
            errs++;
            $display("FAIL stream_add: got %b/%h want %b/12", obs8(), b.sram_addr_op, e);
        end
        send(LD, 8'h34);
        step();
        e = {1'b1, 5'b01000, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h34) begin
            errs++;
            $display("FAIL stream_ld: got %b/%h want %b/34", obs8(), b.sram_addr_op, e);
        end
        send(LDL, 8'h56);
        step();
        e = {1'b1, 5'b01000, 7'b1000000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h56) begin
            errs++;
            $display("FAIL stream_ldl: got %b/%h want %b/56", obs8(), b.sram_addr_op, e);
        end
        idle();
        step();
        vecs++;
        if (b.out_valid_op !== 1'b0) begin
            errs++;
            $display("FAIL stream_drain: got valid %b want 0", b.out_valid_op);
        end
    endtask

    task automatic test_skip();
        logic [13:0] e;
        b.out_ready_ip = 1'b1;
        b.zero_ip = 1'b1;
        send(SKZ, 8'h00);
        step();
        b.zero_ip = 1'b0;
        vecs++;
        if (b.out_valid_op !== 1'b0) begin
            errs++;
            $display("FAIL skz_not_emitted: got valid %b want 0", b.out_valid_op);
        end
        send(XOR_, 8'h05);
        step();
        vecs++;
        if (b.out_valid_op !== 1'b0) begin
            errs++;
            $display("FAIL skz_squash_xor: got valid %b want 0", b.out_valid_op);
        end
        send(OR_, 8'h06);
        step();
        e = {1'b1, 5'b00011, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h06) begin
            errs++;
            $display("FAIL skz_then_or: got %b/%h want %b/06", obs8(), b.sram_addr_op, e);
        end
        send(SKZ, 8'h00);
        step();
        send(XOR_, 8'h07);
        step();
        e = {1'b1, 5'b00101, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h07) begin
            errs++;
            $display("FAIL noskip_xor: got %b/%h want %b/07", obs8(), b.sram_addr_op, e);
        end
        send(OR_, 8'h08);
        step();
        e = {1'b1, 5'b00011, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h08) begin
            errs++;
            $display("FAIL noskip_or: got %b/%h want %b/08", obs8(), b.sram_addr_op, e);
        end
        idle();
        step();
    endtask

    task automatic test_halt();
        logic [13:0] e;
        b.out_ready_ip = 1'b1;
        send(HALT, 8'h00);
        step();
        send(ST, 8'h01);
        #1;
        e = {1'b0, 5'b11111, 7'b0000000, 1'b1};
        vecs++;
        if (obs8() !== e || b.instr_ready_op !== 1'b0) begin
            errs++;
            $display("FAIL halt_entered: got %b rdy %b want %b rdy 0", obs8(), b.instr_ready_op, e);
        end
        step();
        step();
        vecs++;
        if (obs8() !== e || b.instr_ready_op !== 1'b0) begin
            errs++;
            $display("FAIL halt_holds_st: got %b rdy %b want %b rdy 0", obs8(), b.instr_ready_op, e);
        end
        b.wake_ip = 1'b1;
        step();
        b.wake_ip = 1'b0;
        e = {1'b0, 5'b11111, 7'b0000000, 1'b0};
        vecs++;
        if (obs8() !== e || b.instr_ready_op !== 1'b1) begin
            errs++;
            $display("FAIL wake_run: got %b rdy %b want %b rdy 1", obs8(), b.instr_ready_op, e);
        end
        step();
        e = {1'b1, 5'b01001, 7'b0001000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h01) begin
            errs++;
            $display("FAIL wake_st: got %b/%h want %b/01", obs8(), b.sram_addr_op, e);
        end
        idle();
        step();
    endtask

    task automatic test_backpressure();
        logic [13:0] e;
        b.out_ready_ip = 1'b0;
        send(AND_, 8'h11);
        step();
        e = {1'b1, 5'b00010, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h11) begin
            errs++;
            $display("FAIL bp_and: got %b/%h want %b/11", obs8(), b.sram_addr_op, e);
        end
        send(SUB, 8'h22);
        #1;
        vecs++;
        if (b.instr_ready_op !== 1'b0) begin
            errs++;
            $display("FAIL bp_ready_low: got %b want 0", b.instr_ready_op);
        end
        step();
        step();
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h11) begin
            errs++;
            $display("FAIL bp_stable: got %b/%h want %b/11", obs8(), b.sram_addr_op, e);
        end
        b.out_ready_ip = 1'b1;
        #1;
        vecs++;
        if (b.instr_ready_op !== 1'b1) begin
            errs++;
            $display("FAIL bp_ready_release: got %b want 1", b.instr_ready_op);
        end
        step();
        e = {1'b1, 5'b00001, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h22) begin
            errs++;
            $display("FAIL bp_sub: got %b/%h want %b/22", obs8(), b.sram_addr_op, e);
        end
        idle();
        step();
        vecs++;
        if (b.out_valid_op !== 1'b0) begin
            errs++;
            $display("FAIL bp_no_dup: got valid %b want 0", b.out_valid_op);
        end
    endtask

    task automatic test_flush();
        logic [13:0] e;
        b.out_ready_ip = 1'b0;
        send(NOT_, 8'h33);
        step();
        e = {1'b1, 5'b00100, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h33) begin
            errs++;
            $display("FAIL flush_fill_not: got %b/%h want %b/33", obs8(), b.sram_addr_op, e);
        end
        idle();
        b.flush_ip = 1'b1;
        b.out_ready_ip = 1'b1;
        #1;
        vecs++;
        if (b.instr_ready_op !== 1'b0) begin
            errs++;
            $display("FAIL flush_ready_low: got %b want 0", b.instr_ready_op);
        end
        step();
        b.flush_ip = 1'b0;
        vecs++;
        if (b.out_valid_op !== 1'b0) begin
            errs++;
            $display("FAIL flush_clears_slot: got valid %b want 0", b.out_valid_op);
        end
        b.carry_ip = 1'b1;
        send(SKC, 8'h00);
        step();
        b.carry_ip = 1'b0;
        idle();
        b.flush_ip = 1'b1;
        step();
        b.flush_ip = 1'b0;
        send(OR_, 8'h44);
        step();
        e = {1'b1, 5'b00011, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h44) begin
            errs++;
            $display("FAIL flush_clears_skip: got %b/%h want %b/44", obs8(), b.sram_addr_op, e);
        end
        idle();
        step();
    endtask

    task automatic test_illegal();
        logic [13:0] e;
        b.out_ready_ip = 1'b1;
        send(7'b0000011, 8'h5A);
        step();
        e = {1'b1, 5'b11111, 7'b0000001, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h00) begin
            errs++;
            $display("FAIL illegal_00: got %b/%h want %b/00", obs8(), b.sram_addr_op, e);
        end
        send(7'b0110000, 8'h5B);
        step();
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h5B) begin
            errs++;
            $display("FAIL illegal_01: got %b/%h want %b/5b", obs8(), b.sram_addr_op, e);
        end
        send(RET, 8'h77);
        step();
        e = {1'b1, 5'b11111, 7'b0000100, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h00) begin
            errs++;
            $display("FAIL ret: got %b/%h want %b/00", obs8(), b.sram_addr_op, e);
        end
        send(7'b1100101, 8'h10);
        step();
        e = {1'b1, 5'b11111, 7'b0000010, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h00) begin
            errs++;
            $display("FAIL jump: got %b/%h want %b/00", obs8(), b.sram_addr_op, e);
        end
        send(7'b1000101, 8'h3C);
        step();
        e = {1'b1, 5'b11111, 7'b0100000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h3C) begin
            errs++;
            $display("FAIL bit_instr: got %b/%h want %b/3c", obs8(), b.sram_addr_op, e);
        end
        send(NOP, 8'hFF);
        step();
        vecs++;
        if (b.out_valid_op !== 1'b0) begin
            errs++;
            $display("FAIL nop_consumed: got valid %b want 0", b.out_valid_op);
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        logic [13:0] e;
        b.out_ready_ip = 1'b1;
        send(HALT, 8'h00);
        step();
        idle();
        vecs++;
        if (b.halted_op !== 1'b1) begin
            errs++;
            $display("FAIL mid_halted: got %b want 1", b.halted_op);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if (obs8() !== RST_OBS || b.instr_ready_op !== 1'b1) begin
            errs++;
            $display("FAIL reset_mid_halt: got %b rdy %b want %b rdy 1", obs8(), b.instr_ready_op, RST_OBS);
        end
        b.zero_ip = 1'b1;
        send(SKZ, 8'h00);
        step();
        b.zero_ip = 1'b0;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(ADD, 8'h01);
        step();
        e = {1'b1, 5'b00000, 7'b0010000, 1'b0};
        vecs++;
        if (obs8() !== e || b.sram_addr_op !== 8'h01) begin
            errs++;
            $display("FAIL reset_mid_skip: got %b/%h want %b/01", obs8(), b.sram_addr_op, e);
        end
        idle();
        step();
    endtask

    task automatic test_addr10();
        logic [13:0] e;
        b10.out_ready_ip = 1'b1;
        b10.instr_ip = {ADD, 10'h212};
        b10.instr_valid_ip = 1'b1;
        step();
        e = {1'b1, 5'b00000, 7'b0010000, 1'b0};
        vecs++;
        if (obs10() !== e || b10.sram_addr_op !== 10'h212) begin
            errs++;
            $display("FAIL w10_add: got %b/%h want %b/212", obs10(), b10.sram_addr_op, e);
        end
        b10.instr_ip = {LD, 10'h334};
        step();
        e = {1'b1, 5'b01000, 7'b0010000, 1'b0};
        vecs++;
        if (obs10() !== e || b10.sram_addr_op !== 10'h334) begin
            errs++;
            $display("FAIL w10_ld: got %b/%h want %b/334", obs10(), b10.sram_addr_op, e);
        end
        b10.instr_ip = {LDL, 10'h156};
        step();
        e = {1'b1, 5'b01000, 7'b1000000, 1'b0};
        vecs++;
        if (obs10() !== e || b10.sram_addr_op !== 10'h156) begin
            errs++;
            $display("FAIL w10_ldl: got %b/%h want %b/156", obs10(), b10.sram_addr_op, e);
        end
        b10.instr_valid_ip = 1'b0;
        step();
        vecs++;
        if (b10.out_valid_op !== 1'b0) begin
            errs++;
            $display("FAIL w10_drain: got valid %b want 0", b10.out_valid_op);
        end
    endtask

    initial begin
        b.instr_ip = '0;
        b.instr_valid_ip = 1'b0;
        b.zero_ip = 1'b0;
        b.carry_ip = 1'b0;
        b.flush_ip = 1'b0;
        b.wake_ip = 1'b0;
        b.out_ready_ip = 1'b0;
        b10.instr_ip = '0;
        b10.instr_valid_ip = 1'b0;
        b10.zero_ip = 1'b0;
        b10.carry_ip = 1'b0;
        b10.flush_ip = 1'b0;
        b10.wake_ip = 1'b0;
        b10.out_ready_ip = 1'b0;
        test_reset();
        test_stream();
        test_skip();
        test_halt();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_addr10();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
